// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus bridge: FSM states,
// funct3 size codes and byte-strobe generation.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  // Strobe mask for a 64-bit bus; narrower buses keep the low bits.
  function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Request/grant/response data bus between the LSU (master) and memory (slave).
interface lsu_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] strb;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, strb,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, strb,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Load lane selection plus sign/zero extension of the bus response.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic [2:0]                 size_i,
  output logic [XLEN-1:0]            data_o
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (size_i)
      F3_B:    data_o = XLEN'($signed(w_shifted[7:0]));
      F3_H:    data_o = XLEN'($signed(w_shifted[15:0]));
      F3_W:    data_o = XLEN'($signed(w_shifted[31:0]));
      F3_BU:   data_o = XLEN'(w_shifted[7:0]);
      F3_HU:   data_o = XLEN'(w_shifted[15:0]);
      F3_WU:   data_o = XLEN'(w_shifted[31:0]);
      default: data_o = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// MEM-stage load/store unit: turns each load/store into a bus transaction,
// stalling the pipeline until the response (or an error/timeout) arrives.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [2:0]        mem_size_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic              rd_wen_i,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_wen_o,
  output logic              hold_flag_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  lsu_bus_bridge_if.master  bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]       MAX_SZ   = (XLEN == 64) ? 2'd3 : 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_size;
  logic              r_we;
  logic [4:0]        r_rd_addr;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_op;
  logic [1:0]        w_sz;
  logic [2:0]        w_lowmask;
  logic              w_misalign;
  logic              w_req;
  logic              w_timeout;
  logic [XLEN-1:0]   w_wdata_rep;
  logic [XLEN-1:0]   w_load_val;

  assign w_op = (mem_we_i | mem_re_i) & ~rst;

  // Doubleword codes only exist on a 64-bit bus; clamp to the widest access.
  assign w_sz = (mem_size_i[1:0] > MAX_SZ) ? MAX_SZ : mem_size_i[1:0];

  always_comb begin
    case (w_sz)
      2'd0:    w_lowmask = 3'b000;
      2'd1:    w_lowmask = 3'b001;
      2'd2:    w_lowmask = 3'b011;
      default: w_lowmask = 3'b111;
    endcase
  end

  assign w_misalign = |(mem_addr_i[2:0] & w_lowmask);
  assign w_timeout  = (r_cnt == CNT_LAST);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign w_wdata_rep[8*gi +: 8] =
        (r_size[1:0] == 2'd0) ? r_wdata[7:0] :
        (r_size[1:0] == 2'd1) ? r_wdata[8*(gi%2) +: 8] :
        (r_size[1:0] == 2'd2) ? r_wdata[8*(gi%4) +: 8] :
                                r_wdata[8*gi +: 8];
  end

  lsu_load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .rdata_i (bus.rdata),
    .off_i   (r_addr[OFF_W-1:0]),
    .size_i  (r_size),
    .data_o  (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_op && !w_misalign) begin
            r_addr    <= mem_addr_i;
            r_wdata   <= mem_data_i;
            r_size    <= {mem_size_i[2], w_sz};
            r_we      <= mem_we_i;
            r_rd_addr <= rd_addr_i;
            r_err     <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.gnt) r_cnt <= '0;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.rvalid && !bus.err) r_rd_data <= w_load_val;
          if ((bus.rvalid && bus.err) || (!bus.rvalid && w_timeout)) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    rd_addr_o    = rd_addr_i;
    rd_data_o    = rd_data_i;
    rd_wen_o     = rd_wen_i;
    hold_flag_o  = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op) begin
          rd_wen_o = 1'b0;
          if (w_misalign) begin
            misalign_o = 1'b1;
          end else begin
            hold_flag_o  = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        hold_flag_o = 1'b1;
        rd_wen_o    = 1'b0;
        w_req       = 1'b1;
        if (bus.gnt) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        hold_flag_o = 1'b1;
        rd_wen_o    = 1'b0;
        if (bus.rvalid || w_timeout) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // The frozen EX/MEM still shows the finished op; it is not re-issued.
        w_state_next = ST_IDLE;
        rd_addr_o    = r_rd_addr;
        rd_data_o    = r_rd_data;
        rd_wen_o     = !r_we && !r_err;
        bus_err_o    = r_err;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.req   = w_req;
  assign bus.we    = w_req & r_we;
  assign bus.addr  = w_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.wdata = w_req ? w_wdata_rep : '0;
  assign bus.strb  = w_req ? NB'(strb_gen(r_size[1:0], 3'(r_addr[OFF_W-1:0]))) : '0;

endmodule
